// File: rtl/seq_recog_pkg.sv
// Shared defaults, types and the pattern border helper for the sequence recognizer scheduler.
package seq_recog_pkg;

  localparam int              NCH_D     = 4;
  localparam int              PLEN_D    = 4;
  localparam logic [PLEN_D-1:0] PATTERN_D = 4'b1011;

  typedef logic [$clog2(PLEN_D)-1:0] ctx_t;
  typedef logic [$clog2(NCH_D)-1:0]  ch_t;

  // Longest proper border of the first len bits of pat (MSB-first, plen bits wide).
  function automatic int border_len(input logic [7:0] pat, input int plen, input int len);
    int         best;
    logic       ok;
    logic [7:0] s1;
    logic [7:0] s2;
    best = 0;
    for (int b = 1; b < len; b++) begin
      ok = 1'b1;
      for (int i = 0; i < b; i++) begin
        s1 = pat >> (plen - 1 - i);
        s2 = pat >> (plen - 1 - (len - b + i));
        if (s1[0] != s2[0]) ok = 1'b0;
      end
      if (ok) best = b;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_recog_scheduler_if.sv
// Channel-side bit handshake plus registered, channel-tagged match result.
interface seq_recog_scheduler_if
  import seq_recog_pkg::*;
#(
  parameter int NCH = NCH_D,
  parameter int CW  = $clog2(NCH)
);
  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] in_bit;
  logic [NCH-1:0] in_ready;
  logic [NCH-1:0] clr_ch;
  logic           out_valid;
  logic [CW-1:0]  out_ch;
  logic           out_match;

  modport master (output in_valid, in_bit, clr_ch,
                  input  in_ready, out_valid, out_ch, out_match);
  modport slave  (input  in_valid, in_bit, clr_ch,
                  output in_ready, out_valid, out_ch, out_match);
endinterface

// File: rtl/seq_recog_step.sv
// Combinational KMP step of the Mealy recognizer: (state, bit) -> (next state, match).
// No latency, no flow control.
module seq_recog_step
  import seq_recog_pkg::*;
#(
  parameter int              PLEN    = PLEN_D,
  parameter logic [PLEN-1:0] PATTERN = PATTERN_D,
  localparam int             SW      = $clog2(PLEN)
) (
  input  logic [SW-1:0] k,
  input  logic          b,
  output logic [SW-1:0] nk,
  output logic          match
);

  localparam int BORDER = border_len(8'(PATTERN), PLEN, PLEN);

  int   fail_tab [PLEN];
  logic pat_bit  [PLEN];

  for (genvar m = 0; m < PLEN; m++) begin : g_tab
    assign fail_tab[m] = border_len(8'(PATTERN), PLEN, m);
    assign pat_bit[m]  = PATTERN[PLEN-1-m];
  end

  // Walk failure links until a prefix extends with b or nothing survives.
  always_comb begin
    int   j;
    int   l;
    int   fj;
    logic pj;
    logic done;
    j    = int'(k);
    l    = 0;
    fj   = 0;
    pj   = 1'b0;
    done = 1'b0;
    for (int it = 0; it <= PLEN; it++) begin
      pj = 1'b0;
      fj = 0;
      for (int q = 0; q < PLEN; q++) begin
        if (q == j) begin
          pj = pat_bit[q];
          fj = fail_tab[q];
        end
      end
      if (!done) begin
        if (pj == b) begin
          l    = j + 1;
          done = 1'b1;
        end else if (j == 0) begin
          l    = 0;
          done = 1'b1;
        end else begin
          j = fj;
        end
      end
    end
    match = (l == PLEN);
    nk    = match ? SW'(BORDER) : SW'(l);
  end

endmodule

// File: rtl/seq_recog_scheduler.sv
// Round-robin time-multiplexed pattern recognizer over NCH serial channels; result 1 cycle after grant.
// Sources hold in_valid/in_bit until in_ready; one bit consumed per cycle block-wide.
module seq_recog_scheduler
  import seq_recog_pkg::*;
#(
  parameter int              NCH     = NCH_D,
  parameter int              PLEN    = PLEN_D,
  parameter logic [PLEN-1:0] PATTERN = PATTERN_D,
  localparam int             CW      = $clog2(NCH),
  localparam int             SW      = $clog2(PLEN)
) (
  input  logic clk,
  input  logic rst,
  seq_recog_scheduler_if.slave bus
);

  logic [SW-1:0]  ctx [NCH];
  logic [CW-1:0]  rr_ptr;
  logic           any_vld;
  logic [CW-1:0]  gnt_id;
  logic           grant;
  logic [NCH-1:0] grant_vec;
  logic [SW-1:0]  k_sel;
  logic           b_sel;
  logic [SW-1:0]  step_nk;
  logic           step_match;
  logic           out_valid_q;
  logic [CW-1:0]  out_ch_q;
  logic           out_match_q;

  // Pick the valid channel closest to rr_ptr going upward with wrap.
  always_comb begin
    int d;
    int best_d;
    any_vld = 1'b0;
    gnt_id  = '0;
    best_d  = NCH;
    d       = 0;
    for (int c = 0; c < NCH; c++) begin
      d = (c + NCH - int'(rr_ptr)) % NCH;
      if (bus.in_valid[c] && d < best_d) begin
        best_d  = d;
        gnt_id  = CW'(c);
        any_vld = 1'b1;
      end
    end
  end

  assign grant = any_vld && !rst;

  always_comb begin
    grant_vec = '0;
    for (int c = 0; c < NCH; c++) begin
      grant_vec[c] = grant && (gnt_id == CW'(c));
    end
  end

  assign bus.in_ready = grant_vec;

  // A same-cycle clear means the granted bit starts from the empty state.
  assign k_sel = bus.clr_ch[gnt_id] ? '0 : ctx[gnt_id];
  assign b_sel = bus.in_bit[gnt_id];

  seq_recog_step #(
    .PLEN    (PLEN),
    .PATTERN (PATTERN)
  ) u_step (
    .k     (k_sel),
    .b     (b_sel),
    .nk    (step_nk),
    .match (step_match)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) ctx[c] <= '0;
      rr_ptr      <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_match_q <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (grant_vec[c]) begin
          ctx[c] <= step_nk;
        end else if (bus.clr_ch[c]) begin
          ctx[c] <= '0;
        end
      end
      if (grant) begin
        rr_ptr      <= (int'(gnt_id) == NCH - 1) ? '0 : gnt_id + CW'(1);
        out_valid_q <= 1'b1;
        out_ch_q    <= gnt_id;
        out_match_q <= step_match;
      end else begin
        out_valid_q <= 1'b0;
        out_match_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_match = out_match_q;

endmodule

// File: doc/seq_recog_scheduler.md
Name: seq_recog_scheduler

Overview:
- Time-multiplexes one Mealy sequence-recognizer step function across NCH independent serial bit channels.
- Each channel's recognizer state is held in a per-channel context register.
- A round-robin arbiter grants at most one channel per cycle. The granted bit advances that channel's context, and the match result is reported one cycle later, tagged with the channel id.
- The block sits between the serial input sources and downstream match consumers, replacing NCH separate recognizer instances.

Parameters:
- NCH, 4, number of input channels (2..8).
- PLEN, 4, pattern length in bits (2..8).
- PATTERN, 4'b1011, bit sequence to detect. MSB is the first bit received. Detection is overlapping.
- CW, $clog2(NCH), channel id width.
- SW, $clog2(PLEN), context (state) width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  NCH  per-channel bit-available flag.
- in_bit  in  NCH  per-channel serial data bit.
- in_ready  out  NCH  one-hot grant (or all-zero), combinational from in_valid and rr_ptr.
- clr_ch  in  NCH  per-channel synchronous context clear (to state 0).
- out_valid  out  1  registered; a bit was processed last cycle.
- out_ch  out  CW  registered; channel of that bit.
- out_match  out  1  registered; that bit completed PATTERN on out_ch.

Behaviour:
- Reset (async, rst=1): all contexts=0, rr_ptr=0, out_valid=0, out_ch=0, out_match=0. Whenever rst=1, in_ready=0.
- Context value k (0..PLEN-1): the longest proper prefix of PATTERN that is also a suffix of the channel's bits seen so far.
- Step function, computed KMP-style from PATTERN and evaluated on (k, b):
  - If b equals pattern bit k (counted from MSB): nk=k+1.
  - If nk==PLEN: match=1 and nk becomes the longest proper border of PATTERN.
  - Otherwise follow the failure links. nk=0 if no prefix survives.
- Arbitration:
  - Search channels starting at rr_ptr, ascending with wrap mod NCH; the first with in_valid=1 is granted (in_ready one-hot).
  - If no channel is valid: no grant and rr_ptr holds.
  - A bit is consumed exactly when in_valid&in_ready. Only one bit per cycle block-wide.
  - On grant of channel g: rr_ptr <= (g+1) mod NCH.
- Context update on grant of g: ctx[g] <= step(ctx[g], in_bit[g]).nk. All other contexts hold unless cleared.
- Output register, latency 1: out_valid <= grant, out_ch <= g, out_match <= step.match. With no grant, out_valid <= 0, out_match <= 0, and out_ch holds.
- clr_ch[c]=1 without a grant to c: ctx[c] <= 0.
- clr_ch[c]=1 with a grant to c in the same cycle: clear applies first, so the bit is stepped from state 0. ctx[c] <= step(0,bit).nk and out_match reflects step(0,bit).match.
- clr_ch does not affect arbitration or rr_ptr.
- in_valid held high with no grant: no effect, and the bit is not lost. The source holds it until granted.
- Reset asserted mid-stream: partial matches on all channels are discarded. The output pipeline stage is cleared immediately and asynchronously.
- Single active channel: granted every cycle, giving full throughput for that channel.

Decomposition:
- Package seq_recog_pkg holds:
  - defaults NCH_D=4, PLEN_D=4, PATTERN_D=4'b1011;
  - typedef ctx_t (SW bits);
  - typedef ch_t (CW bits);
  - function border_len() used to build the failure table.
- Sub-module seq_recog_step: combinational, parameters PLEN/PATTERN, inputs (k, b), outputs (nk, match).
- Arbiter and context register file stay in the top-level module.

Test Plan:
- Reset then single channel: ch0 valid with bits 1,0,1,1 → in_ready=4'b0001 each cycle; out_match=1 only in the cycle after the 4th bit, with out_ch=0.
- Overlap: ch1 bits 1,0,1,1,0,1,1 → out_match pulses after bits 4 and 7, with ctx[1]=1 (border "1") after each match.
- Round-robin interleave: ch0 and ch2 valid continuously, each streaming 1011 → grants alternate 0,2,0,2; both channels match (out_ch=0 then out_ch=2), with no cross-channel corruption of context.
- Fairness with late arrival: ch3 valid while rr_ptr=0 and ch1 valid → ch1 is granted first, then ch3; rr_ptr=0 after ch3's grant.
- Clear: ch0 sends 1,0,1, then clr_ch[0] with a grant on bit 1 → no match and ctx[0]=1. A following 0,1,1 → match.
- Async reset mid-operation: ch0 sends 1,0,1; assert rst between clock edges → out_valid drops immediately. After release, 1 alone gives no match; 1,0,1,1 then matches.
